pool_window_gen: RTL

Streaming 2x2 window generator that feeds the max-pooling stage. Accepts one signed feature-map pixel per cycle in raster order from the convolution layer. Buffers one row internally and presents each non-overlapping 2x2 window (stride 2) as four parallel words with a valid/ready handshake. The downstream pooling unit consumes the four words and reduces them to one output.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/pool_line_buf.sv | 27 ++
 rtl/pool_window_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: pixel word format and conv1 map geometry.
package cnn_pkg;

  localparam int DATA_W = 30;

  typedef logic signed [DATA_W-1:0] pixel_t;

  localparam int CONV1_IMG_W = 24;
  localparam int CONV1_IMG_H = 24;

  function automatic logic is_odd(input int v);
    return (v % 2) != 0;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Row buffer for the pooling window generator: one write port, two combinational read taps.
module pool_line_buf #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 24,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr_a,
  output logic signed [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]            rd_addr_b,
  output logic signed [DATA_W-1:0] rd_data_b
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; every slot is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 stride-2 window generator feeding the max-pooling stage.
module pool_window_gen #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = cnn_pkg::CONV1_IMG_W,
  parameter int IMG_H  = cnn_pkg::CONV1_IMG_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic signed [DATA_W-1:0] win_0,
  output logic signed [DATA_W-1:0] win_1,
  output logic signed [DATA_W-1:0] win_2,
  output logic signed [DATA_W-1:0] win_3,
  output logic                     frame_done
);
  import cnn_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  if (is_odd(IMG_W) || is_odd(IMG_H) || IMG_W < 2 || IMG_H < 2) begin : g_bad_geometry
    $error("pool_window_gen: IMG_W and IMG_H must be even and at least 2");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic signed [DATA_W-1:0] bl_hold;
  logic signed [DATA_W-1:0] buf_left;
  logic signed [DATA_W-1:0] buf_right;
  logic pix_xfer, win_xfer, win_load, col_last, row_last, last_win;

  assign in_ready = !win_valid || win_ready;
  assign pix_xfer = in_valid && in_ready;
  assign win_xfer = win_valid && win_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign win_load = pix_xfer && row[0] && col[0];

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (pix_xfer && !row[0]),
    .wr_addr   (col),
    .wr_data   (in_data),
    .rd_addr_a (col - CW'(1)),
    .rd_data_a (buf_left),
    .rd_addr_b (col),
    .rd_data_b (buf_right)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_xfer) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bl_hold <= '0;
    end else if (pix_xfer && row[0] && !col[0]) begin
      bl_hold <= in_data;
    end
  end

  // A load in the same cycle as a window transfer keeps win_valid high with fresh words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_0     <= '0;
      win_1     <= '0;
      win_2     <= '0;
      win_3     <= '0;
      last_win  <= 1'b0;
    end else if (win_load) begin
      win_valid <= 1'b1;
      win_0     <= buf_left;
      win_1     <= buf_right;
      win_2     <= bl_hold;
      win_3     <= in_data;
      last_win  <= row_last && col_last;
    end else if (win_xfer) begin
      win_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= win_xfer && last_win;
  end

endmodule
